edge_timestamp_capture: RTL

EDGE_TIMESTAMP_CAPTURE -- requirements
Module: edge_timestamp_capture

---
 rtl/edge_timestamp_capture_pkg.sv | 74 +++++++
 rtl/edge_timestamp_capture_fifo.sv | 74 +++++++
 rtl/edge_timestamp_capture.sv | 121 ++++++++++++
 3 files changed

// File: rtl/edge_timestamp_capture_pkg.sv
// Shared register map, field positions and entry format for the edge timestamp capture block.
// The EDR_* defines give the expander offsets for CTRL/STATUS/DATA/TIME.
`ifndef EDGE_TIMESTAMP_CAPTURE_EDR_DEFINES
`define EDGE_TIMESTAMP_CAPTURE_EDR_DEFINES
`define EDR_CTRL   2'd0
`define EDR_STATUS 2'd1
`define EDR_DATA   2'd2
`define EDR_TIME   2'd3
`endif

package edge_timestamp_capture_pkg;

  // Offsets from the block base on the expander bus (exp_r / exp_r_load / exp_r_read).
  typedef enum logic [1:0] {
    REG_CTRL   = `EDR_CTRL,
    REG_STATUS = `EDR_STATUS,
    REG_DATA   = `EDR_DATA,
    REG_TIME   = `EDR_TIME
  } reg_addr_t;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_RISE_EN = 1;
  localparam int CTRL_FALL_EN = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_FLUSH   = 15;
  localparam int CTRL_W       = 4;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 3;
  localparam int ST_COUNT_W   = 5;
  localparam int ST_LEVEL     = 8;

  localparam int TS_W         = 16;
  localparam int ENTRY_LEVEL  = 15;
  localparam int ENTRY_TIME_W = 15;

  typedef struct packed {
    logic irq_en;
    logic fall_en;
    logic rise_en;
    logic enable;
  } ctrl_t;

  typedef struct packed {
    logic                    level;
    logic [ENTRY_TIME_W-1:0] stamp;
  } entry_t;

  function automatic entry_t make_entry(input logic level,
                                        input logic [ENTRY_TIME_W-1:0] cnt_low);
    entry_t e;
    e.level = level;
    e.stamp = cnt_low;
    return e;
  endfunction

  function automatic logic [TS_W-1:0] pack_status(input logic not_empty,
                                                  input logic full,
                                                  input logic overflow,
                                                  input logic [ST_COUNT_W-1:0] count,
                                                  input logic level);
    logic [TS_W-1:0] w;
    w = '0;
    w[ST_NOT_EMPTY]                         = not_empty;
    w[ST_FULL]                              = full;
    w[ST_OVERFLOW]                          = overflow;
    w[ST_COUNT_LSB +: ST_COUNT_W]           = count;
    w[ST_LEVEL]                             = level;
    return w;
  endfunction

endpackage

// File: rtl/edge_timestamp_capture_fifo.sv
// ts_fifo: power-of-two timestamp FIFO with same-cycle push/pop and a synchronous flush.
// Handshake: push/pop are single-cycle request strobes taken on the clock edge; a pop is
// accepted only when not empty, a push when not full or when a pop is accepted in the same
// cycle, and flush discards both while emptying the FIFO.
module ts_fifo
  import edge_timestamp_capture_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = TS_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ts_fifo: DEPTH must be a power of two from 2 to 16");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/edge_timestamp_capture.sv
// Edge timestamp capture: synchronizes sig_raw, stamps qualifying edges with a 1 MHz counter
// into ts_fifo. Optional glitch filter enabled by defining EDGE_CAPTURE_GLITCH_FILTER_EN.
module edge_timestamp_capture
  import edge_timestamp_capture_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            sysclk,
  input  logic            sysreset_n,
  input  logic            sig_raw,
  input  logic            tick,
  input  logic [TS_W-1:0] data_in,
  input  logic            ctrl_load,
  input  logic            status_load,
  input  logic            time_load,
  input  logic            data_read,
  output logic [TS_W-1:0] ctrl_out,
  output logic [TS_W-1:0] status_out,
  output logic [TS_W-1:0] data_out,
  output logic [TS_W-1:0] time_out,
  output logic            irq
);

  logic r_sync1;
  logic r_sync2;
  logic r_level;
  logic r_level_d;
  logic w_level_next;

  ctrl_t           r_ctrl;
  logic [TS_W-1:0] r_counter;
  logic            r_ovf;

  logic                  w_rise;
  logic                  w_fall;
  logic                  w_push;
  logic                  w_flush;
  logic                  w_ovf_evt;
  logic [TS_W-1:0]       w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic [ST_COUNT_W-1:0] w_count5;
  entry_t                w_entry;

`ifdef EDGE_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] r_filt;

  // The level only follows sync2 once three consecutive samples agree.
  assign w_level_next = (r_sync2 == r_filt[0] && r_filt[0] == r_filt[1]) ? r_sync2 : r_level;

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) r_filt <= '0;
    else             r_filt <= {r_filt[0], r_sync2};
  end
`else
  assign w_level_next = r_sync2;
`endif

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync1   <= sig_raw;
      r_sync2   <= r_sync1;
      r_level   <= w_level_next;
      r_level_d <= r_level;
    end
  end

  assign w_rise    = r_level & ~r_level_d;
  assign w_fall    = ~r_level & r_level_d;
  assign w_push    = r_ctrl.enable & ((w_rise & r_ctrl.rise_en) | (w_fall & r_ctrl.fall_en));
  assign w_flush   = ctrl_load & data_in[CTRL_FLUSH];
  // A full FIFO with a same-cycle read is a swap, not an overflow.
  assign w_ovf_evt = w_push & w_full & ~data_read & ~w_flush;
  assign w_entry   = make_entry(r_level, r_counter[ENTRY_TIME_W-1:0]);

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_ctrl    <= '0;
      r_counter <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (ctrl_load) r_ctrl <= ctrl_t'(data_in[CTRL_W-1:0]);

      if (time_load)                 r_counter <= data_in;
      else if (tick && r_ctrl.enable) r_counter <= r_counter + 1'b1;

      if (w_ovf_evt)                              r_ovf <= 1'b1;
      else if (status_load && data_in[ST_OVERFLOW]) r_ovf <= 1'b0;
    end
  end

  ts_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W)
  ) u_fifo (
    .i_clk   (sysclk),
    .i_rst_n (sysreset_n),
    .i_push  (w_push),
    .i_pop   (data_read),
    .i_flush (w_flush),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_count5   = ST_COUNT_W'(w_count);
  assign ctrl_out   = {{(TS_W-CTRL_W){1'b0}}, r_ctrl};
  assign status_out = pack_status(~w_empty, w_full, r_ovf, w_count5, r_level);
  assign data_out   = w_head;
  assign time_out   = r_counter;
  assign irq        = ~w_empty & r_ctrl.irq_en;

endmodule
